// File: rtl/dmem_responder.sv
// Data-memory responder: latches a load/store request, waits LATENCY cycles,
// accesses the internal word array and returns a single-cycle ack with rdata/err.
module dmem_responder #(
    parameter int DEPTH   = 65536,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [3:0]  LAT_W   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q;

    logic [15:0] mem [DEPTH];
    logic        in_range;
    logic        mem_we;
    logic [AW-1:0] mem_idx;

    // Full 17-bit compare so out-of-range addresses never alias into the array.
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign mem_idx  = addr_q[AW-1:0];
    assign mem_we   = !reset && (state_q == ACCESS) && we_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = LAT_W;
                    state_d = (LAT_W == 4'd0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ack_d   = 1'b1;
                err_d   = !in_range;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (state_q == ACCESS) begin
                if (!in_range) begin
                    rdata_q <= 16'd0;
                end else if (!we_q) begin
                    rdata_q <= mem[mem_idx];
                end
            end
        end
    end

    // Array has no reset so it maps onto block RAM; reset still blocks the write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances with different DEPTH/LATENCY
// share clock, reset and request fields; each has its own req line.
module tb_dmem_responder;
    logic        clk;
    logic        reset;
    logic        req   [4];
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack   [4];
    logic [15:0] rdata [4];
    logic        err   [4];
    logic        busy  [4];

    int tests = 0;
    int fails = 0;

    // Instance 0: DEPTH 65536 / LAT 2; 1: 256 / 0; 2: 256 / 4; 3: 256 / 3.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int DEP = (gi == 0) ? 65536 : 256;
        localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 0 : (gi == 2) ? 4 : 3;
        dmem_responder #(.DEPTH(DEP), .LATENCY(LAT)) u_dut (
            .clk   (clk),
            .reset (reset),
            .req   (req[gi]),
            .we    (we),
            .addr  (addr),
            .wdata (wdata),
            .ack   (ack[gi]),
            .rdata (rdata[gi]),
            .err   (err[gi]),
            .busy  (busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d; ack cycle n counts negedges after the sampling edge.
    task automatic run(input string tag, input int d, input logic w, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] exp_rd, input logic exp_err);
        int          n;
        logic [15:0] rd;
        logic        e;
        logic        b_first;
        logic        b_ack;
        n = 0; rd = 16'hxxxx; e = 1'bx; b_first = 1'bx; b_ack = 1'bx;
        @(negedge clk);
        req[d] = 1'b1; we = w; addr = a; wdata = wd;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req[d]  = 1'b0;
                b_first = busy[d];
            end
            if (ack[d] === 1'b1) begin
                n = i; rd = rdata[d]; e = err[d]; b_ack = busy[d];
                break;
            end
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat_of(d) + 2));
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        chk({tag, "_rdata"}, {16'd0, rd}, {16'd0, exp_rd});
        chk({tag, "_busy1"}, {31'd0, b_first}, 32'd1);
        chk({tag, "_busyack"}, {31'd0, b_ack}, 32'd0);
        $display("[TB] %s inst=%0d we=%0b addr=%04h lat=%0d rdata=%04h err=%0b", tag, d, w, a, n, rd, e);
    endtask

    initial begin
        int acks;
        int pos;
        reset = 1'b1; we = 1'b0; addr = 16'd0; wdata = 16'd0;
        for (int i = 0; i < 4; i++) req[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_state", {13'd0, ack[i], err[i], busy[i], rdata[i]}, 32'd0);
        end
        reset = 1'b0;

        // Store then load, LATENCY 2; a store leaves rdata untouched.
        run("st_beef", 0, 1'b1, 16'h0001, 16'hBEEF, 16'h0000, 1'b0);
        run("ld_beef", 0, 1'b0, 16'h0001, 16'h0000, 16'hBEEF, 1'b0);
        run("st_1357", 0, 1'b1, 16'h0002, 16'h1357, 16'hBEEF, 1'b0);
        run("ld_1357", 0, 1'b0, 16'h0002, 16'h0000, 16'h1357, 1'b0);

        // Idle hold after a load of 0x00FF.
        run("st_00ff", 0, 1'b1, 16'h0003, 16'h00FF, 16'h1357, 1'b0);
        run("ld_00ff", 0, 1'b0, 16'h0003, 16'h0000, 16'h00FF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold", {13'd0, ack[0], busy[0], err[0], rdata[0]}, 32'h0000_00FF);
        end

        // Preload instance 1 and run three back-to-back loads with req held high.
        run("pre_10", 1, 1'b1, 16'h0010, 16'h1111, 16'h0000, 1'b0);
        run("pre_11", 1, 1'b1, 16'h0011, 16'h2222, 16'h0000, 1'b0);
        run("pre_12", 1, 1'b1, 16'h0012, 16'h3333, 16'h0000, 1'b0);
        run("pre_00", 1, 1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0);
        @(negedge clk);
        req[1] = 1'b1; we = 1'b0; addr = 16'h0010;
        @(negedge clk);
        chk("b2b_gap0", {30'd0, ack[1], busy[1]}, 32'd1);
        @(negedge clk);
        chk("b2b_ack0", {15'd0, ack[1], rdata[1]}, 32'h0001_1111);
        addr = 16'h0011;
        @(negedge clk);
        chk("b2b_gap1", {30'd0, ack[1], busy[1]}, 32'd1);
        @(negedge clk);
        chk("b2b_ack1", {15'd0, ack[1], rdata[1]}, 32'h0001_2222);
        addr = 16'h0012;
        @(negedge clk);
        chk("b2b_gap2", {30'd0, ack[1], busy[1]}, 32'd1);
        @(negedge clk);
        chk("b2b_ack2", {15'd0, ack[1], rdata[1]}, 32'h0001_3333);
        req[1] = 1'b0;
        @(negedge clk);
        chk("b2b_end", {30'd0, ack[1], busy[1]}, 32'd0);
        $display("[TB] b2b inst=1 rdata=%04h", rdata[1]);

        // Out-of-range store on DEPTH 256 must not alias onto word 0.
        run("oor_st", 1, 1'b1, 16'h0100, 16'hFFFF, 16'h0000, 1'b1);
        run("oor_ld0", 1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0);

        // Inputs changed and req dropped during WAIT, LATENCY 4.
        @(negedge clk);
        req[2] = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h1234;
        acks = 0; pos = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req[2] = 1'b0; addr = 16'h0021; wdata = 16'h0000;
            end
            if (i == 3) begin
                we = 1'b0;
            end
            if (ack[2] === 1'b1) begin
                acks++; pos = i;
            end
        end
        chk("mid_acks", 32'(acks), 32'd1);
        chk("mid_pos", 32'(pos), 32'd6);
        $display("[TB] mid inst=2 acks=%0d pos=%0d", acks, pos);
        run("mid_ld20", 2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);

        // Reset during WAIT, LATENCY 3: store aborted, no ack.
        run("rst_pre", 3, 1'b1, 16'h0005, 16'h0055, 16'h0000, 1'b0);
        run("rst_ld0", 3, 1'b0, 16'h0005, 16'h0000, 16'h0055, 1'b0);
        @(negedge clk);
        req[3] = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 16'hAAAA;
        @(negedge clk);
        req[3] = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_state", {13'd0, ack[3], err[3], busy[3], rdata[3]}, 32'd0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[3] === 1'b1 || busy[3] === 1'b1) acks++;
        end
        chk("rst_noack", 32'(acks), 32'd0);
        $display("[TB] reset-abort inst=3 activity=%0d", acks);
        run("rst_ld1", 3, 1'b0, 16'h0005, 16'h0000, 16'h0055, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
